// File: rtl/clusterv_irq_router_pkg.sv
// Shared register map and sizing helpers for the clusterv interrupt router.
package clusterv_irq_router_pkg;

  localparam logic [15:0] PRIO_BASE   = 16'h0000;
  localparam logic [15:0] PRIO_STRIDE = 16'h0004;
  localparam logic [15:0] PENDING_OFF = 16'h0080;
  localparam logic [15:0] TRIG_OFF    = 16'h0084;
  localparam logic [15:0] CORE_BASE   = 16'h0100;
  localparam logic [15:0] CORE_STRIDE = 16'h0040;
  localparam logic [15:0] ENABLE_OFF  = 16'h0000;
  localparam logic [15:0] THRESH_OFF  = 16'h0004;
  localparam logic [15:0] CLAIM_OFF   = 16'h0008;

  // Source IDs run 1..n_srcs with 0 reserved for "no candidate".
  function automatic int id_width(input int n_srcs);
    return $clog2(n_srcs + 1);
  endfunction

endpackage

// File: rtl/clusterv_irq_arb.sv
// Per-core arbiter: highest priority above threshold wins, ties go to the lowest ID.
module clusterv_irq_arb #(
  parameter int N_SRCS = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4
) (
  input  logic [N_SRCS-1:0]        pending_i,
  input  logic [N_SRCS-1:0]        enable_i,
  input  logic [N_SRCS*PRIO_W-1:0] prio_i,
  input  logic [PRIO_W-1:0]        threshold_i,
  output logic [ID_W-1:0]          id_o,
  output logic                     valid_o
);

  logic [PRIO_W-1:0] best_prio_s;
  logic [ID_W-1:0]   best_id_s;

  // Seeding with the threshold makes the strict compare enforce both PRIO>THRESHOLD and lowest-ID ties.
  always_comb begin
    best_prio_s = threshold_i;
    best_id_s   = '0;
    for (int i = 0; i < N_SRCS; i++) begin
      if (pending_i[i] && enable_i[i] && (prio_i[i*PRIO_W +: PRIO_W] > best_prio_s)) begin
        best_prio_s = prio_i[i*PRIO_W +: PRIO_W];
        best_id_s   = ID_W'(i + 1);
      end
    end
  end

  assign id_o    = best_id_s;
  assign valid_o = (best_id_s != '0);

endmodule

// File: rtl/clusterv_irq_router.sv
// Wishbone-programmable interrupt router with claim/complete per core.
// Optional rising-edge triggering is enabled by defining CLUSTERV_IRQ_ROUTER_EDGE_EN.
module clusterv_irq_router
  import clusterv_irq_router_pkg::*;
#(
  parameter int N_SRCS  = 8,
  parameter int N_CORES = 4,
  parameter int PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        rt_adr,
  input  logic [31:0]        rt_dat_w,
  output logic [31:0]        rt_dat_r,
  input  logic               rt_cyc,
  input  logic               rt_stb,
  input  logic               rt_we,
  input  logic [3:0]         rt_sel,
  output logic               rt_ack,
  output logic               rt_err,
  input  logic [N_SRCS-1:0]  src,
  output logic [N_CORES-1:0] irq
);

  localparam int ID_W = id_width(N_SRCS);

  logic                     served_q;
  logic                     ack_q;
  logic [31:0]              dat_r_q, dat_r_d;
  logic [PRIO_W-1:0]        prio_q   [N_SRCS];
  logic [PRIO_W-1:0]        prio_d   [N_SRCS];
  logic [N_SRCS-1:0]        enable_q [N_CORES];
  logic [N_SRCS-1:0]        enable_d [N_CORES];
  logic [PRIO_W-1:0]        thresh_q [N_CORES];
  logic [PRIO_W-1:0]        thresh_d [N_CORES];
  logic [N_SRCS-1:0]        pending_q, pending_d;
  logic [N_SRCS-1:0]        in_service_q, in_service_d;
  logic [N_CORES-1:0]       irq_q;
  logic [N_CORES-1:0]       cand_valid_s;
  logic [ID_W-1:0]          cand_id_s [N_CORES];
  logic [N_SRCS*PRIO_W-1:0] prio_flat_s;
  logic                     req_first_s;
  logic [N_SRCS-1:0]        claim_clr_s, complete_clr_s;
  logic [N_SRCS-1:0]        trig_s, level_set_s, edge_set_s;
  logic                     unused_s;

  assign unused_s = ^rt_sel;

`ifdef CLUSTERV_IRQ_ROUTER_EDGE_EN
  logic [N_SRCS-1:0] trig_q, trig_d;
  logic [N_SRCS-1:0] src_prev_q;

  // Trigger-mode register and previous-sample flops for rising-edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      trig_q     <= '0;
      src_prev_q <= '0;
    end else begin
      trig_q     <= trig_d;
      src_prev_q <= src;
    end
  end

  assign trig_s     = trig_q;
  assign edge_set_s = src & ~src_prev_q & trig_q;
`else
  assign trig_s     = '0;
  assign edge_set_s = '0;
`endif

  for (genvar i = 0; i < N_SRCS; i++) begin : g_flat
    assign prio_flat_s[i*PRIO_W +: PRIO_W] = prio_q[i];
  end

  for (genvar c = 0; c < N_CORES; c++) begin : g_arb
    clusterv_irq_arb #(
      .N_SRCS (N_SRCS),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
    ) u_arb (
      .pending_i   (pending_q),
      .enable_i    (enable_q[c]),
      .prio_i      (prio_flat_s),
      .threshold_i (thresh_q[c]),
      .id_o        (cand_id_s[c]),
      .valid_o     (cand_valid_s[c])
    );
  end

  // Register decode: only the first cycle of a strobe performs the access.
  always_comb begin
    req_first_s    = rt_cyc & rt_stb & ~served_q;
    prio_d         = prio_q;
    enable_d       = enable_q;
    thresh_d       = thresh_q;
    dat_r_d        = 32'h0;
    claim_clr_s    = '0;
    complete_clr_s = '0;
`ifdef CLUSTERV_IRQ_ROUTER_EDGE_EN
    trig_d         = trig_q;
`endif
    if (req_first_s) begin
      for (int i = 0; i < N_SRCS; i++) begin
        if (rt_adr == PRIO_BASE + PRIO_STRIDE * 16'(i)) begin
          if (rt_we) prio_d[i] = rt_dat_w[PRIO_W-1:0];
          else       dat_r_d   = 32'(prio_q[i]);
        end
      end
      if (rt_adr == PENDING_OFF && !rt_we) dat_r_d = 32'(pending_q);
`ifdef CLUSTERV_IRQ_ROUTER_EDGE_EN
      if (rt_adr == TRIG_OFF) begin
        if (rt_we) trig_d  = rt_dat_w[N_SRCS-1:0];
        else       dat_r_d = 32'(trig_q);
      end
`else
      if (rt_adr == TRIG_OFF) dat_r_d = 32'h0;
`endif
      for (int c = 0; c < N_CORES; c++) begin
        if (rt_adr == CORE_BASE + CORE_STRIDE * 16'(c) + ENABLE_OFF) begin
          if (rt_we) enable_d[c] = rt_dat_w[N_SRCS-1:0];
          else       dat_r_d     = 32'(enable_q[c]);
        end
        if (rt_adr == CORE_BASE + CORE_STRIDE * 16'(c) + THRESH_OFF) begin
          if (rt_we) thresh_d[c] = rt_dat_w[PRIO_W-1:0];
          else       dat_r_d     = 32'(thresh_q[c]);
        end
        if (rt_adr == CORE_BASE + CORE_STRIDE * 16'(c) + CLAIM_OFF) begin
          for (int i = 0; i < N_SRCS; i++) begin
            if (rt_we) begin
              if (rt_dat_w == 32'(i + 1) && in_service_q[i]) complete_clr_s[i] = 1'b1;
            end else begin
              if (cand_valid_s[c] && cand_id_s[c] == ID_W'(i + 1)) claim_clr_s[i] = 1'b1;
            end
          end
          if (!rt_we) dat_r_d = 32'(cand_id_s[c]);
        end
      end
    end
  end

  // Claim is applied before new source activity; an edge arriving with the claim still latches.
  always_comb begin
    level_set_s  = src & ~trig_s & ~in_service_q & ~claim_clr_s;
    pending_d    = (pending_q & ~claim_clr_s) | level_set_s | edge_set_s;
    in_service_d = (in_service_q | claim_clr_s) & ~complete_clr_s;
  end

  // State register for bus handshake, configuration and interrupt tracking.
  always_ff @(posedge clock) begin
    if (!reset) begin
      served_q     <= 1'b0;
      ack_q        <= 1'b0;
      dat_r_q      <= 32'h0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_q        <= '0;
      for (int i = 0; i < N_SRCS; i++) prio_q[i] <= '0;
      for (int c = 0; c < N_CORES; c++) begin
        enable_q[c] <= '0;
        thresh_q[c] <= '0;
      end
    end else begin
      served_q     <= rt_cyc & rt_stb;
      ack_q        <= req_first_s;
      dat_r_q      <= dat_r_d;
      prio_q       <= prio_d;
      enable_q     <= enable_d;
      thresh_q     <= thresh_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_q        <= cand_valid_s;
    end
  end

  assign rt_ack   = ack_q;
  assign rt_dat_r = dat_r_q;
  assign rt_err   = 1'b0;
  assign irq      = irq_q;

endmodule

// File: doc/clusterv_irq_router.md
CLUSTERV_IRQ_ROUTER -- requirements
Module: clusterv_irq_router

Interface
REQ-001 SHALL have parameter N_SRCS, default 8, number of interrupt sources (legal range 1..31).
REQ-002 SHALL have parameter N_CORES, default 4, number of core interrupt targets (legal range 1..4).
REQ-003 SHALL have parameter PRIO_W, default 3, width of the priority and threshold fields.
REQ-004 SHALL have port clock  in  1  single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-006 SHALL have a Wishbone target port group rt_ (adr 16, dat_w 32, dat_r 32, cyc, stb, we, sel 4, ack, err) for register access.
REQ-007 SHALL have port src  in  N_SRCS  interrupt source lines; source i has ID i+1.
REQ-008 SHALL have port irq  out  N_CORES  interrupt request, one per core.

Function
REQ-009 SHALL decode the register map as follows:
  - PRIO[i] at 0x000+4*i (RW, PRIO_W bits; value 0 disables the source).
  - PENDING at 0x080 (RO, bit i = source i).
  - Per core c, at base 0x100+0x40*c: ENABLE +0x00 (RW, N_SRCS bits), THRESHOLD +0x04 (RW, PRIO_W bits), CLAIM/COMPLETE +0x08.
REQ-010 SHALL assert rt_ack for exactly one cycle, one cycle after the first cycle of rt_cyc&rt_stb, and SHALL not ack again until stb drops or a new cycle begins.
REQ-011 SHALL, for an unmapped address, ack with rt_dat_r=0 and ignore writes; rt_err SHALL be 0 always.
REQ-012 SHALL, in level mode, set pending[i] on the cycle after src[i] is sampled high while in_service[i]=0.
REQ-013 SHALL compute per core the candidate: pending & ENABLE & PRIO>THRESHOLD, highest PRIO wins, ties resolved to the lowest ID; ID 0 means no candidate.
REQ-014 SHALL drive irq[c] registered, high iff core c has a candidate; latency from src high to irq high SHALL be 2 cycles.
REQ-015 SHALL, on a CLAIM read, return the current candidate ID and in the same ack cycle clear pending and set in_service for that ID; a read with no candidate SHALL return 0 and change no state.
REQ-016 SHALL, on a COMPLETE write of ID k whose in_service bit is set, clear in_service[k-1]; writes of 0, of an out-of-range ID, or of an ID not in service SHALL be ignored.
REQ-017 SHALL let a source that is still high after complete re-pend on the following cycle.
REQ-018 SHALL, when a CLAIM and a src edge for the same source coincide, apply the claim first; in edge mode the new edge SHALL be latched into pending.
REQ-019 SHALL ignore writes to the PRIO, ENABLE and THRESHOLD bits above their defined widths, which SHALL read back as 0.

Reset
REQ-020 SHALL, while reset=0 at a clock edge, clear PRIO, ENABLE, THRESHOLD, pending, in_service, irq, rt_ack and rt_dat_r.
REQ-021 SHALL, when reset is asserted mid-operation, abandon any in-flight bus access without ack and lose all claimed state.

Configuration
REQ-022 SHALL, with CLUSTERV_IRQ_ROUTER_EDGE_EN defined, provide a TRIG register at 0x084 (RW, bit i=1 selects rising-edge mode for source i).
REQ-023 SHALL, in edge mode, set pending[i] on a 0->1 transition of src[i] regardless of in_service, with one-deep latching.
REQ-024 SHALL, without CLUSTERV_IRQ_ROUTER_EDGE_EN, treat all sources as level, read TRIG as 0, ignore writes to TRIG, and contain no edge-detect flops.

Structure
REQ-025 SHALL place the register offsets, the core stride, and the ID-width constant (clog2 of N_SRCS+1) in package clusterv_irq_router_pkg.
REQ-026 SHALL implement per-core priority selection in sub-module clusterv_irq_arb, instantiated N_CORES times in a generate loop.

Verification
REQ-027 SHALL verify: PRIO[2]=5, ENABLE0=0x4, THRESHOLD0=0, src[2]=1 -> irq[0] high 2 cycles later; CLAIM0 returns 3; irq[0] low.
REQ-028 SHALL verify: PRIO[1]=3, PRIO[4]=3, both sources high, both enabled on core 1 -> CLAIM1 returns 2, then after COMPLETE(2) with src[1] low, returns 5.
REQ-029 SHALL verify: THRESHOLD2=4, PRIO[0]=4 -> irq[2] stays low; set THRESHOLD2=3 -> irq[2] high.
REQ-030 SHALL verify: COMPLETE(7) with source 7 not in service -> no state change; read 0x0F0 -> ack, data 0.
REQ-031 SHALL verify, with EDGE_EN: TRIG bit 0=1, two src[0] pulses while in service -> after complete exactly one further claim returns 1, then CLAIM returns 0.
REQ-032 SHALL verify: reset=0 asserted mid-claim -> all registers and irq read 0 afterwards.
